// File: rtl/swiss_timer_pkg.sv
// Shared constants and types for the stopwatch time counter.
package swiss_timer_pkg;

  localparam int DIGIT_W          = 4;
  localparam int DIGIT_MAX        = 9;
  localparam int SEC_TENS_MAX     = 5;
  localparam int MIN_TENS_MAX     = 5;
  localparam int TICK_DIV_DEFAULT = 1_000_000;
  localparam int DIV_W_DEFAULT    = 20;

  // One full MM:SS.cc reading, most significant digit first.
  typedef struct packed {
    logic [DIGIT_W-1:0] min_tens;
    logic [DIGIT_W-1:0] min_ones;
    logic [DIGIT_W-1:0] sec_tens;
    logic [DIGIT_W-1:0] sec_ones;
    logic [DIGIT_W-1:0] centi_tens;
    logic [DIGIT_W-1:0] centi_ones;
  } time_t;

endpackage

// File: rtl/swiss_time_counter_bcd_digit.sv
// One BCD digit of the time chain: counts 0..MAX on carry_in and
// passes a carry on to the next digit in the same cycle it wraps.
module bcd_digit
  import swiss_timer_pkg::*;
#(
  parameter int MAX = DIGIT_MAX
) (
  input  logic               clock100MHz,
  input  logic               reset,
  input  logic               clear,
  input  logic               carry_in,
  output logic [DIGIT_W-1:0] digit,
  output logic               carry_out
);

  localparam logic [DIGIT_W-1:0] MAX_V = DIGIT_W'(MAX);

  logic [DIGIT_W-1:0] count_q;

  // Digit register: clear wins, otherwise advance and wrap on carry_in.
  always_ff @(posedge clock100MHz or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else if (clear) begin
      count_q <= '0;
    end else if (carry_in) begin
      count_q <= (count_q == MAX_V) ? '0 : count_q + 1'b1;
    end
  end

  assign digit     = count_q;
  assign carry_out = carry_in & (count_q == MAX_V);

endmodule

// File: rtl/swiss_time_counter.sv
// Centisecond time base plus MM:SS.cc BCD counter with lap freeze.
// The prescaler produces a one-cycle tick every TICK_DIV enabled cycles;
// six chained BCD digits ripple the carry in a single cycle. A lap
// rising edge toggles between showing the live count and a snapshot.
module swiss_time_counter
  import swiss_timer_pkg::*;
#(
  parameter int TICK_DIV = TICK_DIV_DEFAULT,
  parameter int DIV_W    = DIV_W_DEFAULT
) (
  input  logic               clock100MHz,
  input  logic               reset,
  input  logic               count_Enable,
  input  logic               clear,
  input  logic               lap,
  output logic [DIGIT_W-1:0] centi_Ones,
  output logic [DIGIT_W-1:0] centi_Tens,
  output logic [DIGIT_W-1:0] sec_Ones,
  output logic [DIGIT_W-1:0] sec_Tens,
  output logic [DIGIT_W-1:0] min_Ones,
  output logic [DIGIT_W-1:0] min_Tens,
  output logic               lap_Active,
  output logic               rollover
);

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);

  logic [DIV_W-1:0] div_q;
  logic             tick;
  logic             c_centi_ones, c_centi_tens, c_sec_ones;
  logic             c_sec_tens, c_min_ones, c_min_tens;
  time_t            live;
  time_t            snap_q;
  time_t            disp;
  logic             lap_q;
  logic             lap_active_q;
  logic             rollover_q;
  logic             lap_rise;

  // Clear suppresses the tick so nothing downstream can advance that cycle.
  assign tick     = count_Enable & ~clear & (div_q == DIV_LAST);
  assign lap_rise = lap & ~lap_q;

  // Prescaler: advances only while enabled, so a pause keeps the phase.
  always_ff @(posedge clock100MHz or posedge reset) begin
    if (reset) begin
      div_q <= '0;
    end else if (clear) begin
      div_q <= '0;
    end else if (count_Enable) begin
      div_q <= (div_q == DIV_LAST) ? '0 : div_q + 1'b1;
    end
  end

  bcd_digit #(.MAX(DIGIT_MAX)) u_centi_ones (
    .clock100MHz(clock100MHz), .reset(reset), .clear(clear),
    .carry_in(tick), .digit(live.centi_ones), .carry_out(c_centi_ones)
  );

  bcd_digit #(.MAX(DIGIT_MAX)) u_centi_tens (
    .clock100MHz(clock100MHz), .reset(reset), .clear(clear),
    .carry_in(c_centi_ones), .digit(live.centi_tens), .carry_out(c_centi_tens)
  );

  bcd_digit #(.MAX(DIGIT_MAX)) u_sec_ones (
    .clock100MHz(clock100MHz), .reset(reset), .clear(clear),
    .carry_in(c_centi_tens), .digit(live.sec_ones), .carry_out(c_sec_ones)
  );

  bcd_digit #(.MAX(SEC_TENS_MAX)) u_sec_tens (
    .clock100MHz(clock100MHz), .reset(reset), .clear(clear),
    .carry_in(c_sec_ones), .digit(live.sec_tens), .carry_out(c_sec_tens)
  );

  bcd_digit #(.MAX(DIGIT_MAX)) u_min_ones (
    .clock100MHz(clock100MHz), .reset(reset), .clear(clear),
    .carry_in(c_sec_tens), .digit(live.min_ones), .carry_out(c_min_ones)
  );

  bcd_digit #(.MAX(MIN_TENS_MAX)) u_min_tens (
    .clock100MHz(clock100MHz), .reset(reset), .clear(clear),
    .carry_in(c_min_ones), .digit(live.min_tens), .carry_out(c_min_tens)
  );

  // Lap edge tracking, snapshot capture, and the registered wrap pulse.
  always_ff @(posedge clock100MHz or posedge reset) begin
    if (reset) begin
      lap_q        <= 1'b0;
      lap_active_q <= 1'b0;
      snap_q       <= '0;
      rollover_q   <= 1'b0;
    end else begin
      lap_q      <= lap;
      rollover_q <= c_min_tens;
      if (clear) begin
        lap_active_q <= 1'b0;
        snap_q       <= '0;
      end else if (lap_rise) begin
        if (!lap_active_q) begin
          snap_q       <= live;
          lap_active_q <= 1'b1;
        end else begin
          lap_active_q <= 1'b0;
        end
      end
    end
  end

  // Display mux selects between two register banks only.
  assign disp       = lap_active_q ? snap_q : live;
  assign centi_Ones = disp.centi_ones;
  assign centi_Tens = disp.centi_tens;
  assign sec_Ones   = disp.sec_ones;
  assign sec_Tens   = disp.sec_tens;
  assign min_Ones   = disp.min_ones;
  assign min_Tens   = disp.min_tens;
  assign lap_Active = lap_active_q;
  assign rollover   = rollover_q;

endmodule

// File: tb/tb_swiss_time_counter.sv
// Directed bench for swiss_time_counter with a 4-cycle tick divider.
module tb_swiss_time_counter;

  logic       clock100MHz;
  logic       reset;
  logic       count_Enable;
  logic       clear;
  logic       lap;
  logic [3:0] centi_Ones, centi_Tens, sec_Ones, sec_Tens, min_Ones, min_Tens;
  logic       lap_Active;
  logic       rollover;

  logic [23:0] disp;
  logic [23:0] exp_q[$];
  int          n_checks;
  int          n_fail;
  int          tick_count;
  logic [3:0]  prev_centi;

  swiss_time_counter #(.TICK_DIV(4), .DIV_W(20)) dut (
    .clock100MHz (clock100MHz),
    .reset       (reset),
    .count_Enable(count_Enable),
    .clear       (clear),
    .lap         (lap),
    .centi_Ones  (centi_Ones),
    .centi_Tens  (centi_Tens),
    .sec_Ones    (sec_Ones),
    .sec_Tens    (sec_Tens),
    .min_Ones    (min_Ones),
    .min_Tens    (min_Tens),
    .lap_Active  (lap_Active),
    .rollover    (rollover)
  );

  // Display as a BCD-readable word: 24'hMMSScc.
  assign disp = {min_Tens, min_Ones, sec_Tens, sec_Ones, centi_Tens, centi_Ones};

  // Clock and reset block
  initial clock100MHz = 1'b0;
  always #5 clock100MHz = ~clock100MHz;

  // Count displayed centisecond changes, sampled away from the active edge.
  initial prev_centi = 4'd0;
  always @(negedge clock100MHz) begin
    if (centi_Ones !== prev_centi) tick_count++;
    prev_centi = centi_Ones;
  end

  task automatic step(input int n);
    repeat (n) @(posedge clock100MHz);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic expect_disp(input logic [23:0] v);
    exp_q.push_back(v);
  endtask

  // Scoreboard: compare the display with the oldest expected reading.
  task automatic check_disp(input string tag);
    logic [23:0] e;
    e = exp_q.pop_front();
    check(tag, {8'h0, disp}, {8'h0, e});
  endtask

  initial begin
    n_checks = 0;
    n_fail = 0;
    tick_count = 0;
    reset = 1'b1;
    count_Enable = 1'b0;
    clear = 1'b0;
    lap = 1'b0;
    step(3);
    expect_disp(24'h000000); check_disp("reset_disp");
    check("reset_lap", {31'h0, lap_Active}, 32'h0);
    check("reset_roll", {31'h0, rollover}, 32'h0);
    reset = 1'b0;
    step(1);

    // 400 enabled cycles -> 100 ticks -> 00:01.00
    tick_count = 0;
    count_Enable = 1'b1;
    step(400);
    count_Enable = 1'b0;
    step(1);
    expect_disp(24'h000100); check_disp("run400_disp");
    check("run400_ticks", tick_count, 32'd100);

    // Pause after 2 prescaler cycles, resume mid-period
    count_Enable = 1'b1;
    step(2);
    count_Enable = 1'b0;
    step(50);
    expect_disp(24'h000100); check_disp("pause_hold");
    count_Enable = 1'b1;
    step(1);
    expect_disp(24'h000100); check_disp("resume_1");
    step(1);
    expect_disp(24'h000101); check_disp("resume_2");

    // Run on to 00:03.27, then reset asynchronously mid-cycle
    step(904);
    expect_disp(24'h000327); check_disp("pre_reset");
    reset = 1'b1;
    #1;
    expect_disp(24'h000000); check_disp("async_reset_disp");
    check("async_reset_lap", {31'h0, lap_Active}, 32'h0);
    check("async_reset_roll", {31'h0, rollover}, 32'h0);
    count_Enable = 1'b0;
    step(2);
    reset = 1'b0;
    step(1);

    // Preload 59:59.99 and wrap
    force dut.u_min_tens.count_q = 4'd5;
    force dut.u_min_ones.count_q = 4'd9;
    force dut.u_sec_tens.count_q = 4'd5;
    force dut.u_sec_ones.count_q = 4'd9;
    force dut.u_centi_tens.count_q = 4'd9;
    force dut.u_centi_ones.count_q = 4'd9;
    #1;
    release dut.u_min_tens.count_q;
    release dut.u_min_ones.count_q;
    release dut.u_sec_tens.count_q;
    release dut.u_sec_ones.count_q;
    release dut.u_centi_tens.count_q;
    release dut.u_centi_ones.count_q;
    #1;
    expect_disp(24'h595999); check_disp("preload");
    count_Enable = 1'b1;
    step(3);
    expect_disp(24'h595999); check_disp("wrap_before");
    check("wrap_roll_before", {31'h0, rollover}, 32'h0);
    step(1);
    expect_disp(24'h000000); check_disp("wrap_after");
    check("wrap_roll_pulse", {31'h0, rollover}, 32'h1);
    step(1);
    check("wrap_roll_end", {31'h0, rollover}, 32'h0);
    expect_disp(24'h000000); check_disp("wrap_continue");

    // Lap: freeze at 00:12.34, release showing 00:12.44
    clear = 1'b1;
    step(1);
    clear = 1'b0;
    expect_disp(24'h000000); check_disp("clear_before_lap");
    step(4936);
    expect_disp(24'h001234); check_disp("lap_start_value");
    lap = 1'b1;
    step(1);
    check("lap_active_on", {31'h0, lap_Active}, 32'h1);
    expect_disp(24'h001234); check_disp("lap_frozen_0");
    step(20);
    expect_disp(24'h001234); check_disp("lap_frozen_20");
    lap = 1'b0;
    step(19);
    expect_disp(24'h001234); check_disp("lap_frozen_39");
    check("lap_still_on", {31'h0, lap_Active}, 32'h1);
    lap = 1'b1;
    step(1);
    expect_disp(24'h001244); check_disp("lap_release_live");
    check("lap_active_off", {31'h0, lap_Active}, 32'h0);

    // Clear coincident with a tick at 00:00.99 while a lap is held
    count_Enable = 1'b0;
    clear = 1'b1;
    step(1);
    clear = 1'b0;
    expect_disp(24'h000000); check_disp("clear2_disp");
    lap = 1'b0;
    step(1);
    lap = 1'b1;
    step(1);
    check("lap2_on", {31'h0, lap_Active}, 32'h1);
    count_Enable = 1'b1;
    step(396);
    step(3);
    expect_disp(24'h000000); check_disp("lap2_snapshot");
    clear = 1'b1;
    step(1);
    clear = 1'b0;
    expect_disp(24'h000000); check_disp("clear_tick_disp");
    check("clear_tick_lap", {31'h0, lap_Active}, 32'h0);
    check("clear_tick_roll", {31'h0, rollover}, 32'h0);
    step(1);
    check("clear_tick_roll_next", {31'h0, rollover}, 32'h0);
    expect_disp(24'h000000); check_disp("clear_tick_next");
    step(2);
    expect_disp(24'h000000); check_disp("post_clear_3");
    step(1);
    expect_disp(24'h000001); check_disp("post_clear_tick");
    count_Enable = 1'b0;
    step(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
